fft32_stage_ctrl: RTL and testbench

//  Frame sequencer for the 32-point FFT pipeline. Accepts one 32-sample frame
//  as 8 beats of 4 lanes, then steps the butterfly datapath through NSTAGE

---
 rtl/fft32_stage_ctrl_pkg.sv | 27 ++
 rtl/fft32_stage_ctrl_delay_line.sv | 25 ++
 rtl/fft32_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_fft32_stage_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fft32_stage_ctrl_pkg.sv
// rtl/fft32_stage_ctrl_pkg.sv - shared constants and state encoding for the FFT frame sequencer
package fft32_stage_ctrl_pkg;

    localparam int FFT_NCYC   = 8;
    localparam int FFT_NSTAGE = 2;
    localparam int ROM_LAT    = 1;
    localparam int BF_LAT     = 3;

    localparam int BEAT_W     = $clog2(FFT_NCYC);
    localparam int STAGE_W    = 2;
    localparam int DRAIN_CYC  = ROM_LAT + BF_LAT;
    localparam int CNT_W      = $clog2(DRAIN_CYC + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FFT_NCYC - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(FFT_NSTAGE - 1);
    localparam logic [CNT_W-1:0]   LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

endpackage

// File: rtl/fft32_stage_ctrl_delay_line.sv
// rtl/fft32_stage_ctrl_delay_line.sv - synchronously cleared shift register, DEPTH stages of WIDTH bits
module fft32_stage_ctrl_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft32_stage_ctrl.sv
// rtl/fft32_stage_ctrl.sv - frame sequencer: load, per-stage twiddle runs with aligned writeback, output stream
import fft32_stage_ctrl_pkg::*;

module fft32_stage_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic               out_last_o,
    output logic               rom_start_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic [BEAT_W-1:0]  beat_o,
    output logic [BEAT_W-1:0]  wb_addr_o,
    output logic               buf_we_o,
    output logic               bf_en_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [STAGE_W-1:0] stage_q;
    logic [CNT_W-1:0]   drain_q;
    logic               done_q;

    logic run_beat;
    logic bf_en;
    logic wb_we;
    logic load_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            stage_q <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        beat_q  <= beat_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid_i) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            stage_q <= '0;
                            state_q <= ST_ARM;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_ARM: state_q <= ST_RUN;
                ST_RUN: begin
                    if (beat_q == LAST_BEAT) begin
                        drain_q <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                // Next stage is armed only after the last writeback has left the pipe.
                ST_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        beat_q <= '0;
                        if (stage_q == LAST_STAGE) begin
                            state_q <= ST_OUT;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= ST_ARM;
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            stage_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign run_beat = (state_q == ST_RUN);

    fft32_stage_ctrl_delay_line #(.WIDTH(1), .DEPTH(ROM_LAT)) u_bf_en_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (run_beat),
        .q_o   (bf_en)
    );

    fft32_stage_ctrl_delay_line #(.WIDTH(1), .DEPTH(BF_LAT)) u_wb_we_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bf_en),
        .q_o   (wb_we)
    );

    fft32_stage_ctrl_delay_line #(.WIDTH(BEAT_W), .DEPTH(ROM_LAT + BF_LAT)) u_wb_addr_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (beat_q),
        .q_o   (wb_addr_o)
    );

    // Input is refused while reset is held so a reset cycle never writes the buffer.
    assign in_ready_o  = ~rst_i & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign load_we     = in_valid_i & in_ready_o;
    assign buf_we_o    = load_we | wb_we;
    assign bf_en_o     = bf_en;
    assign out_valid_o = (state_q == ST_OUT);
    assign out_last_o  = (state_q == ST_OUT) & (beat_q == LAST_BEAT);
    assign rom_start_o = (state_q == ST_ARM);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign stage_o     = stage_q;
    assign beat_o      = beat_q;

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// tb/tb_fft32_stage_ctrl.sv - randomized bench for fft32_stage_ctrl against a cycle-offset reference model
module tb_fft32_stage_ctrl;

    localparam int NCYC    = 8;
    localparam int NSTAGE  = 2;
    localparam int ROM_LAT = 1;
    localparam int BF_LAT  = 3;
    localparam int STEP    = 1 + NCYC + ROM_LAT + BF_LAT;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready_o;
    logic       out_ready;
    logic       out_valid_o;
    logic       out_last_o;
    logic       rom_start_o;
    logic [1:0] stage_o;
    logic [2:0] beat_o;
    logic [2:0] wb_addr_o;
    logic       buf_we_o;
    logic       bf_en_o;
    logic       busy_o;
    logic       done_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int m_phase     = 0;
    int m_cnt       = 0;
    int m_t0        = 0;
    int m_done_at   = -1;
    int frames_done = 0;
    bit rst_prev    = 1'b0;

    fft32_stage_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .rom_start_o (rom_start_o),
        .stage_o     (stage_o),
        .beat_o      (beat_o),
        .wb_addr_o   (wb_addr_o),
        .buf_we_o    (buf_we_o),
        .bf_en_o     (bf_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: phases of a frame with expected outputs derived from cycle offsets.
    always @(negedge clk) begin
        int o, s, r;
        bit wb;
        if (rst) begin
            if (rst_prev) begin
                check_eq("rst_in_ready",  int'(in_ready_o),  0);
                check_eq("rst_out_valid", int'(out_valid_o), 0);
                check_eq("rst_out_last",  int'(out_last_o),  0);
                check_eq("rst_rom_start", int'(rom_start_o), 0);
                check_eq("rst_stage",     int'(stage_o),     0);
                check_eq("rst_beat",      int'(beat_o),      0);
                check_eq("rst_buf_we",    int'(buf_we_o),    0);
                check_eq("rst_bf_en",     int'(bf_en_o),     0);
                check_eq("rst_busy",      int'(busy_o),      0);
                check_eq("rst_done",      int'(done_o),      0);
            end
            m_phase   = 0;
            m_cnt     = 0;
            m_done_at = -1;
        end else begin
            check_eq("done", int'(done_o), int'(cyc == m_done_at));
            case (m_phase)
                0: begin
                    check_eq("in_ready",       int'(in_ready_o),  1);
                    check_eq("busy_load",      int'(busy_o),      int'(m_cnt > 0));
                    check_eq("beat_load",      int'(beat_o),      m_cnt);
                    check_eq("buf_we_load",    int'(buf_we_o),    int'(in_valid));
                    check_eq("out_valid_load", int'(out_valid_o), 0);
                    check_eq("rom_start_load", int'(rom_start_o), 0);
                    check_eq("bf_en_load",     int'(bf_en_o),     0);
                    if (in_valid) begin
                        m_cnt++;
                        if (m_cnt == NCYC) begin
                            m_phase = 1;
                            m_cnt   = 0;
                            m_t0    = cyc + 1;
                        end
                    end
                end
                1: begin
                    o  = cyc - m_t0;
                    s  = o / STEP;
                    r  = o % STEP;
                    wb = (r >= 1 + ROM_LAT + BF_LAT) && (r <= NCYC + ROM_LAT + BF_LAT);
                    check_eq("rom_start", int'(rom_start_o), int'(r == 0));
                    check_eq("stage",     int'(stage_o),     s);
                    if (r >= 1 && r <= NCYC) check_eq("run_beat", int'(beat_o), r - 1);
                    check_eq("bf_en", int'(bf_en_o), int'((r >= 1 + ROM_LAT) && (r <= NCYC + ROM_LAT)));
                    check_eq("wb_we", int'(buf_we_o), int'(wb));
                    if (wb) check_eq("wb_addr", int'(wb_addr_o), r - 1 - ROM_LAT - BF_LAT);
                    check_eq("in_ready_proc",  int'(in_ready_o),  0);
                    check_eq("busy_proc",      int'(busy_o),      1);
                    check_eq("out_valid_early", int'(out_valid_o), 0);
                    if (o == NSTAGE * STEP - 1) begin
                        m_phase = 2;
                        m_cnt   = 0;
                    end
                end
                default: begin
                    check_eq("out_valid",   int'(out_valid_o), 1);
                    check_eq("out_beat",    int'(beat_o),      m_cnt);
                    check_eq("out_last",    int'(out_last_o),  int'(m_cnt == NCYC - 1));
                    check_eq("in_ready_out", int'(in_ready_o), 0);
                    check_eq("buf_we_out",  int'(buf_we_o),    0);
                    check_eq("busy_out",    int'(busy_o),      1);
                    if (out_ready) begin
                        m_cnt++;
                        if (m_cnt == NCYC) begin
                            m_phase   = 0;
                            m_cnt     = 0;
                            m_done_at = cyc + 1;
                            frames_done++;
                        end
                    end
                end
            endcase
        end
        rst_prev = rst;
    end

    task automatic run_frames(input int n, input int vpct, input int rpct, input bit hold_last);
        int start;
        int budget;
        int hold;
        start  = frames_done;
        budget = 0;
        hold   = 0;
        while (frames_done < start + n && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
            in_valid = ($urandom_range(99) < vpct);
            if (!out_last_o) hold = 0;
            if (hold_last && out_last_o && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
        end
        check_eq("frames_completed", frames_done - start, n);
    endtask

    task automatic mid_run_reset();
        int budget;
        budget    = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!rom_start_o && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("arm_reached", int'(rom_start_o), 1);
        repeat (3) begin @(posedge clk); #1; end
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        run_frames(1, 100, 100, 1'b0);
        run_frames(2, 60, 100, 1'b0);
        run_frames(2, 100, 100, 1'b1);
        run_frames(3, 70, 50, 1'b1);
        mid_run_reset();
        run_frames(3, 100, 100, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
